// File: rtl/riscv_fetch_unit.sv
// RISC-V instruction fetch stage: owns the fetch PC, keeps at most one word read
// in flight, and buffers returned words with their PCs in a 2-entry FIFO for decode.
module riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        req_pc_q;

    logic [31:0]        buf_pc   [FIFO_DEPTH];
    logic [31:0]        buf_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic               req_fire;
    logic               push;
    logic               pop;
    logic [31:0]        redirect_target;

    // The reset term keeps the request low while reset is held, even though
    // the registered state already sits in REQ with an empty buffer.
    assign imem_req_valid  = rst && (state_q == REQ) && (count_q < CNT_W'(FIFO_DEPTH));
    assign imem_req_addr   = fetch_pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;

    assign instr_valid     = (count_q != '0);
    assign instr           = buf_data[rd_ptr_q];
    assign instr_pc        = buf_pc[rd_ptr_q];

    // A redirect empties the buffer, so neither a returning word nor a pop lands.
    assign push            = (state_q == WAIT) && imem_rsp_valid && !redirect;
    assign pop             = instr_valid && instr_ready && !redirect;
    assign redirect_target = redirect_pc & ~32'h3;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;

        case (state_q)
            REQ: begin
                if (req_fire) begin
                    state_d    = WAIT;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // Redirect overrides the normal flow; an in-flight read becomes wrong-path.
        if (redirect) begin
            fetch_pc_d = redirect_target;
            case (state_q)
                REQ:     state_d = req_fire ? DROP : REQ;
                WAIT,
                DROP:    state_d = imem_rsp_valid ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (req_fire) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

    // NOTE: the buffer storage is reset because instr/instr_pc must read zero
    // out of reset; it is only two entries, so this stays cheap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr_q]   <= req_pc_q;
                buf_data[wr_ptr_q] <= imem_rsp_data;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed scenarios plus a randomized run,
// all compared cycle by cycle against a queue-based model of the fetch stage.
module tb_riscv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int pops  = 0;

    // Memory responder: one pending read, answered mem_lat cycles after its handshake.
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;

    // Reference model: expected buffer contents, outstanding read and next fetch address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[$];
    logic        m_out      = 1'b0;
    logic        m_stale    = 1'b0;
    logic [31:0] m_fetch_pc = 32'h0;
    logic [31:0] m_req_pc   = 32'h0;

    logic        last_hs       = 1'b0;
    logic [31:0] last_hs_addr  = 32'h0;
    logic        last_pop      = 1'b0;
    logic [31:0] last_pop_pc   = 32'h0;
    logic [31:0] last_pop_data = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00a0_0213;
            32'h0000_0004: return 32'h0140_0293;
            32'h0000_0008: return 32'hff62_0213;
            default:       return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_out      = 1'b0;
        m_stale    = 1'b0;
        m_fetch_pc = 32'h0;
    endtask

    // One clock: drive memory response, check pre-edge outputs, then advance the model.
    task automatic step();
        logic        p_rv, p_iv, exp_rv, do_push;
        logic [31:0] p_ra, p_i, p_ipc, i_rpc;
        logic        i_rdy, i_rsp, i_redir, i_irdy, i_rst;

        @(negedge clk);
        if (mem_pend && mem_cnt > 0) mem_cnt--;
        imem_rsp_valid = mem_pend && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : 32'h0;
        #1;
        p_rv = imem_req_valid;  p_ra = imem_req_addr;
        p_iv = instr_valid;     p_i = instr;       p_ipc = instr_pc;
        i_rdy = imem_req_ready; i_rsp = imem_rsp_valid; i_redir = redirect;
        i_rpc = redirect_pc;    i_irdy = instr_ready;   i_rst = rst;

        if (i_rst) begin
            exp_rv = !m_out && (mq.size() < 2);
            tests++;
            if (p_rv !== exp_rv) begin
                fails++;
                $display("FAIL req_valid cyc=%0d got=%b exp=%b", cycle, p_rv, exp_rv);
            end
            if (exp_rv) begin
                tests++;
                if (p_ra !== m_fetch_pc) begin
                    fails++;
                    $display("FAIL req_addr cyc=%0d got=%h exp=%h", cycle, p_ra, m_fetch_pc);
                end
            end
            tests++;
            if (p_iv !== (mq.size() != 0)) begin
                fails++;
                $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cycle, p_iv, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                tests++;
                if (p_ipc !== mq[0].pc || p_i !== mq[0].data) begin
                    fails++;
                    $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                             cycle, p_ipc, p_i, mq[0].pc, mq[0].data);
                end
            end
        end

        @(posedge clk);
        #1;
        cycle++;
        last_hs  = 1'b0;
        last_pop = 1'b0;

        if (i_rsp) mem_pend = 1'b0;
        if (p_rv && i_rdy) begin
            tests++;
            if (mem_pend) begin
                fails++;
                $display("FAIL outstanding cyc=%0d second request addr=%h while one pending", cycle, p_ra);
            end
            mem_pend     = 1'b1;
            mem_addr     = p_ra;
            mem_cnt      = mem_lat;
            last_hs      = 1'b1;
            last_hs_addr = p_ra;
        end

        if (i_rst) begin
            do_push = 1'b0;
            if (i_rsp && m_out) begin
                if (!i_redir && !m_stale) begin
                    do_push = 1'b1;
                    tests++;
                    if (mq.size() >= 2) begin
                        fails++;
                        $display("FAIL overflow cyc=%0d response into full buffer size=%0d", cycle, mq.size());
                    end
                end
                m_out = 1'b0;
            end
            if (p_iv && i_irdy && !i_redir && mq.size() != 0) begin
                last_pop      = 1'b1;
                last_pop_pc   = mq[0].pc;
                last_pop_data = mq[0].data;
                pops++;
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back('{pc: m_req_pc, data: mem_word(m_req_pc)});
            if (p_rv && i_rdy) begin
                m_out    = 1'b1;
                m_stale  = 1'b0;
                m_req_pc = m_fetch_pc;
                if (!i_redir) m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (i_redir) begin
                mq.delete();
                m_fetch_pc = i_rpc & ~32'h3;
                if (m_out) m_stale = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect       = 1'b0;
        mem_pend       = 1'b0;
        mem_lat        = 1;
        rst            = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_hs(input int budget, input string what);
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_hs && n < budget);
        tests++;
        if (!last_hs) begin
            fails++;
            $display("FAIL %s timeout: no request handshake in %0d cycles", what, budget);
        end
    endtask

    task automatic wait_pop(input int budget, input string what);
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_pop && n < budget);
        tests++;
        if (!last_pop) begin
            fails++;
            $display("FAIL %s timeout: no instruction delivered in %0d cycles", what, budget);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        tests++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs got req_valid=%b instr_valid=%b instr=%h pc=%h addr=%h exp 0 0 0 0 0",
                     imem_req_valid, instr_valid, instr, instr_pc, imem_req_addr);
        end
        model_reset();
        step();
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_words[3] = '{32'h00a00213, 32'h01400293, 32'hff620213};
        int          pop_cyc[3];
        int          k = 0;
        int          n = 0;
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        while (k < 3 && n < 40) begin
            step();
            n++;
            if (last_pop) begin
                pop_cyc[k] = cycle;
                tests++;
                if (last_pop_pc !== 32'(4 * k) || last_pop_data !== exp_words[k]) begin
                    fails++;
                    $display("FAIL stream[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                             k, last_pop_pc, last_pop_data, 32'(4 * k), exp_words[k]);
                end
                k++;
            end
        end
        tests++;
        if (k != 3) begin
            fails++;
            $display("FAIL stream_count got=%0d exp=3", k);
        end else begin
            for (int i = 1; i < 3; i++) begin
                tests++;
                if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
                    fails++;
                    $display("FAIL stream_gap[%0d] got=%0d exp=2", i, pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready = 1'b1;
        repeat (6) step();
        tests++;
        if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL bp_full got instr_valid=%b req_valid=%b pc=%h exp 1 0 00000000",
                     instr_valid, imem_req_valid, instr_pc);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        tests++;
        if (!last_pop || last_pop_pc !== 32'h0) begin
            fails++;
            $display("FAIL bp_pop got pop=%b pc=%h exp 1 00000000", last_pop, last_pop_pc);
        end
        tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
            fails++;
            $display("FAIL bp_req got valid=%b addr=%h exp 1 00000008", imem_req_valid, imem_req_addr);
        end
        step();
        tests++;
        if (!last_hs || last_hs_addr !== 32'h8) begin
            fails++;
            $display("FAIL bp_hs got hs=%b addr=%h exp 1 00000008", last_hs, last_hs_addr);
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || last_hs) begin
                fails++;
                $display("FAIL stall[%0d] got valid=%b addr=%h hs=%b exp 1 00000000 0",
                         i, imem_req_valid, imem_req_addr, last_hs);
            end
        end
        imem_req_ready = 1'b1;
        step();
        tests++;
        if (!last_hs || last_hs_addr !== 32'h0) begin
            fails++;
            $display("FAIL stall_hs got hs=%b addr=%h exp 1 00000000", last_hs, last_hs_addr);
        end
        wait_pop(10, "stall_deliver");
        tests++;
        if (last_pop_pc !== 32'h0) begin
            fails++;
            $display("FAIL stall_pc got=%h exp=00000000", last_pop_pc);
        end
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mem_lat        = 2;
        do begin
            step();
            n++;
        end while (!(last_hs && last_hs_addr == 32'h4) && n < 20);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL rdw_flush got instr_valid=%b req_valid=%b exp 0 0", instr_valid, imem_req_valid);
        end
        wait_hs(10, "rdw_req");
        tests++;
        if (last_hs_addr !== 32'h100) begin
            fails++;
            $display("FAIL rdw_addr got=%h exp=00000100", last_hs_addr);
        end
        wait_pop(10, "rdw_deliver");
        tests++;
        if (last_pop_pc !== 32'h100) begin
            fails++;
            $display("FAIL rdw_pc got=%h exp=00000100", last_pop_pc);
        end
    endtask

    task automatic test_redirect_pop_rsp();
        int n = 0;
        do_reset();
        imem_req_ready = 1'b1;
        do begin
            step();
            n++;
        end while (!(last_hs && last_hs_addr == 32'h4) && n < 20);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL rpr_setup got instr_valid=%b pc=%h exp 1 00000000", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
            fails++;
            $display("FAIL rpr_after got instr_valid=%b req_valid=%b addr=%h exp 0 1 00000040",
                     instr_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mem_lat        = 3;
        wait_hs(10, "rmw_req");
        imem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        tests++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            instr_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
            fails++;
            $display("FAIL rmw_outputs got req_valid=%b instr_valid=%b instr=%h pc=%h addr=%h exp 0 0 0 0 0",
                     imem_req_valid, instr_valid, instr, instr_pc, imem_req_addr);
        end
        model_reset();
        step();
        rst = 1'b1;
        repeat (3) step();
        tests++;
        if (instr_valid !== 1'b0 || mem_pend) begin
            fails++;
            $display("FAIL rmw_late got instr_valid=%b pending=%b exp 0 0", instr_valid, mem_pend);
        end
        imem_req_ready = 1'b1;
        wait_pop(20, "rmw_refetch");
        tests++;
        if (last_pop_pc !== 32'h0) begin
            fails++;
            $display("FAIL rmw_pc got=%h exp=00000000", last_pop_pc);
        end
    endtask

    task automatic test_random();
        int start_pops;
        do_reset();
        start_pops = pops;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            mem_lat        = int'($urandom_range(1, 3));
            redirect       = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            step();
        end
        redirect = 1'b0;
        tests++;
        if (pops - start_pops < 20) begin
            fails++;
            $display("FAIL random_progress got=%0d delivered exp>=20", pops - start_pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_mem_stall();
        test_redirect_wait();
        test_redirect_pop_rsp();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
